ahfp_add_pipe: RTL and testbench

AHFP_ADD_PIPE -- requirements
Module: ahfp_add_pipe

---
 rtl/ahfp_pkg.sv | 25 ++
 rtl/ahfp_add_pipe_if.sv | 14 +
 rtl/ahfp_lzc.sv | 18 +
 rtl/ahfp_add_pipe.sv | 183 ++++++++++++++++++
 tb/tb_ahfp_add_pipe.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ahfp_pkg.sv
// Shared definitions for the AHFP floating-point blocks: default field widths,
// exponent bias, canonical quiet NaN and operand classification.
package ahfp_pkg;

  localparam int unsigned AHFP_EXP_W = 8;
  localparam int unsigned AHFP_MAN_W = 23;

  // Classification of an operand once split into its fields
  typedef struct packed {
    logic sign;
    logic zero;
    logic inf;
    logic nan;
  } ahfp_unpk_t;

  function automatic int unsigned ahfp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Sign 0, exponent all ones, mantissa MSB set; caller slices to its width
  function automatic logic [63:0] ahfp_qnan(input int unsigned exp_w, input int unsigned man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/ahfp_add_pipe_if.sv
// Operand/result bundle for ahfp_add_pipe; clk and reset stay outside.
interface ahfp_add_pipe_if #(
  parameter int unsigned W = 32
) ();
  logic         clk_en;
  logic         start;
  logic [W-1:0] dataa;
  logic [W-1:0] datab;
  logic [W-1:0] result;
  logic         done;

  modport master (output clk_en, start, dataa, datab, input result, done);
  modport slave  (input clk_en, start, dataa, datab, output result, done);
endinterface

// File: rtl/ahfp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns DATA_W.
module ahfp_lzc #(
  parameter int unsigned DATA_W = 27,
  parameter int unsigned CW     = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [CW-1:0]     o_count
);

  // Scanning upward lets the highest set bit win
  always_comb begin
    o_count = CW'(DATA_W);
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i_data[i]) o_count = CW'(DATA_W - 1 - i);
    end
  end

endmodule

// File: rtl/ahfp_add_pipe.sv
// Three-stage flush-to-zero floating-point adder (align / add / normalise+round).
// Define AHFP_ADD_RNE_EN for round-to-nearest-even; otherwise results truncate.
module ahfp_add_pipe
  import ahfp_pkg::*;
#(
  parameter  int unsigned EXP_W = AHFP_EXP_W,
  parameter  int unsigned MAN_W = AHFP_MAN_W,
  localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en,
  input  logic         start,
  input  logic [W-1:0] dataa,
  input  logic [W-1:0] datab,
  output logic [W-1:0] result,
  output logic         done
);

  localparam int unsigned SW  = MAN_W + 4;          // hidden + mantissa + G/R/S
  localparam int unsigned CW  = $clog2(SW + 1);
  localparam int unsigned EW2 = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = W'(ahfp_qnan(EXP_W, MAN_W));
`ifdef AHFP_ADD_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  // ---------------- S1: unpack, compare, swap, align ----------------
  logic [EXP_W-1:0]       w_ea, w_eb, w_big_exp, w_small_exp, w_diff;
  logic [MAN_W-1:0]       w_ma, w_mb;
  logic [EXP_W+MAN_W-1:0] w_mag_a, w_mag_b;
  logic [MAN_W:0]         w_big_sig, w_small_sig;
  logic [SW-1:0]          w_ext, w_shift, w_mask, w_aligned, w_big_ext;
  ahfp_unpk_t             w_ua, w_ub;
  logic                   w_swap, w_sign, w_spec;
  logic [W-1:0]           w_spec_val;

  always_comb begin
    w_ea = dataa[MAN_W +: EXP_W];
    w_eb = datab[MAN_W +: EXP_W];
    w_ma = dataa[MAN_W-1:0];
    w_mb = datab[MAN_W-1:0];

    w_ua.sign = dataa[W-1];
    w_ua.zero = (w_ea == '0);
    w_ua.inf  = (w_ea == EXP_ONES) && (w_ma == '0);
    w_ua.nan  = (w_ea == EXP_ONES) && (w_ma != '0);
    w_ub.sign = datab[W-1];
    w_ub.zero = (w_eb == '0);
    w_ub.inf  = (w_eb == EXP_ONES) && (w_mb == '0);
    w_ub.nan  = (w_eb == EXP_ONES) && (w_mb != '0);

    // Denormals compare and add as zero
    w_mag_a = w_ua.zero ? '0 : {w_ea, w_ma};
    w_mag_b = w_ub.zero ? '0 : {w_eb, w_mb};
    w_swap  = (w_mag_b > w_mag_a);

    w_big_exp   = w_swap ? w_eb : w_ea;
    w_small_exp = w_swap ? w_ea : w_eb;
    w_big_sig   = w_swap ? (w_ub.zero ? '0 : {1'b1, w_mb}) : (w_ua.zero ? '0 : {1'b1, w_ma});
    w_small_sig = w_swap ? (w_ua.zero ? '0 : {1'b1, w_ma}) : (w_ub.zero ? '0 : {1'b1, w_mb});
    w_sign      = w_swap ? w_ub.sign : w_ua.sign;
    w_diff      = w_big_exp - w_small_exp;

    w_big_ext = {w_big_sig, 3'b000};
    w_ext     = {w_small_sig, 3'b000};
    w_shift   = w_ext >> w_diff;
    w_mask    = ~({SW{1'b1}} << w_diff);
    if (32'(w_diff) >= SW) w_aligned = {{(SW-1){1'b0}}, |w_ext};
    else                   w_aligned = {w_shift[SW-1:1], w_shift[0] | (|(w_ext & w_mask))};

    w_spec     = 1'b0;
    w_spec_val = '0;
    if (w_ua.nan || w_ub.nan || (w_ua.inf && w_ub.inf && (w_ua.sign != w_ub.sign))) begin
      w_spec     = 1'b1;
      w_spec_val = QNAN;
    end else if (w_ua.inf) begin
      w_spec     = 1'b1;
      w_spec_val = {w_ua.sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_ub.inf) begin
      w_spec     = 1'b1;
      w_spec_val = {w_ub.sign, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  logic             r1_valid, r1_sign, r1_sub, r1_spec;
  logic [EXP_W-1:0] r1_exp;
  logic [SW-1:0]    r1_big, r1_small;
  logic [W-1:0]     r1_spec_val;

  // ---------------- S2: magnitude add / subtract ----------------
  logic [SW:0] w_sum;

  always_comb begin
    if (r1_sub) w_sum = {1'b0, r1_big} - {1'b0, r1_small};
    else        w_sum = {1'b0, r1_big} + {1'b0, r1_small};
  end

  logic             r2_valid, r2_sign, r2_sub, r2_spec;
  logic [EXP_W-1:0] r2_exp;
  logic [SW:0]      r2_sum;
  logic [W-1:0]     r2_spec_val;

  // ---------------- S3: normalise, round, pack ----------------
  logic [CW-1:0]  w_lz;
  logic [SW-1:0]  w_norm;
  logic [EW2-1:0] w_exp_n, w_exp_f;
  logic [MAN_W+1:0] w_rnd;
  logic [MAN_W-1:0] w_man;
  logic           w_uflow, w_inc;
  logic [W-1:0]   w_res;

  ahfp_lzc #(
    .DATA_W (SW),
    .CW     (CW)
  ) u_lzc (
    .i_data  (r2_sum[SW-1:0]),
    .o_count (w_lz)
  );

  always_comb begin
    w_uflow = 1'b0;
    if (r2_sum[SW]) begin
      w_norm  = {r2_sum[SW:2], r2_sum[1] | r2_sum[0]};
      w_exp_n = {2'b00, r2_exp} + EW2'(1);
    end else begin
      w_norm  = r2_sum[SW-1:0] << w_lz;
      w_exp_n = {2'b00, r2_exp} - EW2'(w_lz);
      w_uflow = (EW2'(w_lz) >= {2'b00, r2_exp});
    end

    // Mantissa carry-out from rounding bumps the exponent and leaves a zero mantissa
    w_inc = RNE_EN & w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rnd = {1'b0, w_norm[SW-1:3]} + (MAN_W+2)'(w_inc);
    if (w_rnd[MAN_W+1]) begin
      w_man   = w_rnd[MAN_W:1];
      w_exp_f = w_exp_n + EW2'(1);
    end else begin
      w_man   = w_rnd[MAN_W-1:0];
      w_exp_f = w_exp_n;
    end

    if (r2_spec)                             w_res = r2_spec_val;
    else if (r2_sum == '0)                   w_res = {(r2_sub ? 1'b0 : r2_sign), {(W-1){1'b0}}};
    else if (w_uflow)                        w_res = '0;
    else if (w_exp_f >= {2'b00, EXP_ONES})   w_res = {r2_sign, EXP_ONES, {MAN_W{1'b0}}};
    else                                     w_res = {r2_sign, w_exp_f[EXP_W-1:0], w_man};
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
    end else if (clk_en) begin
      r1_valid    <= start;
      r1_sign     <= w_sign;
      r1_sub      <= w_ua.sign ^ w_ub.sign;
      r1_exp      <= w_big_exp;
      r1_big      <= w_big_ext;
      r1_small    <= w_aligned;
      r1_spec     <= w_spec;
      r1_spec_val <= w_spec_val;

      r2_valid    <= r1_valid;
      r2_sign     <= r1_sign;
      r2_sub      <= r1_sub;
      r2_exp      <= r1_exp;
      r2_sum      <= w_sum;
      r2_spec     <= r1_spec;
      r2_spec_val <= r1_spec_val;

      done <= r2_valid;
      if (r2_valid) result <= w_res;
    end
  end

endmodule

// File: tb/tb_ahfp_add_pipe.sv
// Scoreboard bench for ahfp_add_pipe against an exact big-integer reference sum.
// Expectations follow AHFP_ADD_RNE_EN the same way the design build does.
module tb_ahfp_add_pipe;

`ifdef AHFP_ADD_RNE_EN
  localparam bit RNE_EN = 1'b1;
  localparam logic [31:0] EXP_033 = 32'h3F800001;
  localparam logic [31:0] EXP_TIE = 32'h3F800002;
`else
  localparam bit RNE_EN = 1'b0;
  localparam logic [31:0] EXP_033 = 32'h3F800000;
  localparam logic [31:0] EXP_TIE = 32'h3F800001;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        d_use;
  logic [31:0] d_exp;
  bit          stim_done = 1'b0;

  ahfp_add_pipe_if #(.W(32)) bus ();

  ahfp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (bus.clk_en),
    .start  (bus.start),
    .dataa  (bus.dataa),
    .datab  (bus.datab),
    .result (bus.result),
    .done   (bus.done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // Reference: operands as exact integers in units of 2^-149, summed and rounded once
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, s, rne_inc;
    logic [7:0] ea, eb;
    logic [22:0] ma, mb;
    logic [299:0] va, vb, v, rem, half, one;
    logic [24:0] sig;
    int p, e;
    sa = a[31]; ea = a[30:23]; ma = a[22:0];
    sb = b[31]; eb = b[30:23]; mb = b[22:0];
    if ((ea == 8'hFF && ma != 0) || (eb == 8'hFF && mb != 0)) return 32'h7FC00000;
    if (ea == 8'hFF && eb == 8'hFF) return (sa == sb) ? {sa, 8'hFF, 23'h0} : 32'h7FC00000;
    if (ea == 8'hFF) return {sa, 8'hFF, 23'h0};
    if (eb == 8'hFF) return {sb, 8'hFF, 23'h0};
    one = 300'd1;
    va = (ea == 0) ? '0 : ({276'd0, 1'b1, ma} << (int'(ea) - 1));
    vb = (eb == 0) ? '0 : ({276'd0, 1'b1, mb} << (int'(eb) - 1));
    if (sa == sb)      begin v = va + vb; s = sa; end
    else if (va >= vb) begin v = va - vb; s = sa; end
    else               begin v = vb - va; s = sb; end
    if (v == 0) return (sa == sb) ? {sa, 31'h0} : 32'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (v[i]) p = i;
    e = p - 22;
    if (e < 1) return 32'h0;
    sig = 25'(v >> (p - 23));
    if (p > 23) begin
      rem = v & ((one << (p - 23)) - one);
      half = one << (p - 24);
      rne_inc = (rem > half) || (rem == half && sig[0]);
      if (RNE_EN && rne_inc) sig = sig + 25'd1;
    end
    if (sig[24]) begin sig = sig >> 1; e++; end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    return {s, 8'(e), sig[22:0]};
  endfunction

  function automatic logic [31:0] rand_op(input logic [31:0] near);
    logic [31:0] r;
    int e;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: case ($urandom_range(0, 7))
           0: r = 32'h00000000;
           1: r = 32'h80000000;
           2: r = 32'h7F800000;
           3: r = 32'hFF800000;
           4: r = {1'b0, 8'hFF, 1'b1, r[21:0]};
           5: r = {r[31], 8'h00, r[22:0]};
           6: r = {r[31], 8'hFF, 22'h0, 1'b1};
           default: r = {r[31], 8'h01, r[22:0]};
         endcase
      1, 2, 3: begin
        e = int'(near[30:23]) + int'($urandom_range(0, 6)) - 3;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        r = {r[31], 8'(e), r[22:0]};
      end
      4: r = {r[31], 8'hFE, r[22:0]};
      5: r = {~near[31], near[30:3], r[2:0]};
      default: r[30:23] = 8'($urandom_range(1, 254));
    endcase
    return r;
  endfunction

  typedef struct {
    logic [31:0] val;
    logic [31:0] a;
    logic [31:0] b;
    int unsigned tag;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned en_cyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  logic [31:0] last_res = '0;
  bit          armed = 1'b0;
  bit          was_rst = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Push on every accepted start; check outputs on the falling edge
  always begin
    exp_t e;
    @(posedge clk);
    was_rst = reset;
    if (reset) begin
      exp_q.delete();
      last_res = '0;
      armed = 1'b1;
    end else if (bus.clk_en) begin
      if (bus.start) begin
        e.val = d_use ? d_exp : ref_add(bus.dataa, bus.datab);
        e.a = bus.dataa;
        e.b = bus.datab;
        e.tag = en_cyc;
        exp_q.push_back(e);
      end
      en_cyc++;
    end
    @(negedge clk);
    if (armed) begin
      if (was_rst) begin
        check("reset_result", bus.result, 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
      end
      if (bus.done && bus.clk_en) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_done: done high with no pending operation, result %h", bus.result);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("sum %h+%h", e.a, e.b), bus.result, e.val);
          check("latency", en_cyc - e.tag, 32'd3);
          last_res = e.val;
        end
      end else if (!bus.done) begin
        check("hold_result", bus.result, last_res);
      end
    end
    if (stim_done) begin
      check("drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  task automatic cyc(input logic en, input logic st, input logic rs,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic use_c, input logic [31:0] ev);
    bus.clk_en = en;
    bus.start  = st;
    reset      = rs;
    bus.dataa  = a;
    bus.datab  = b;
    d_use      = use_c;
    d_exp      = ev;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [31:0] a, b;
    // Reset with clk_en low on one edge and start asserted throughout
    cyc(1'b0, 1'b1, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0, '0);
    idle(3);

    // Isolated start, then directed vectors back to back
    cyc(1'b1, 1'b1, 1'b0, 32'h3F800000, 32'h3F000000, 1'b1, 32'h3FC00000);
    idle(4);
    cyc(1'b1, 1'b1, 1'b0, 32'h3F800000, 32'hBF800000, 1'b1, 32'h00000000);
    cyc(1'b1, 1'b1, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000);
    cyc(1'b1, 1'b1, 1'b0, 32'h7F800000, 32'hFF800000, 1'b1, 32'h7FC00000);
    cyc(1'b1, 1'b1, 1'b0, 32'h7FC00001, 32'h3F800000, 1'b1, 32'h7FC00000);
    cyc(1'b1, 1'b1, 1'b0, 32'h3F800000, 32'h33C00000, 1'b1, EXP_033);
    cyc(1'b1, 1'b1, 1'b0, 32'h3F800001, 32'h33800000, 1'b1, EXP_TIE);
    cyc(1'b1, 1'b1, 1'b0, 32'h3F800000, 32'h34000000, 1'b1, 32'h3F800001);
    cyc(1'b1, 1'b1, 1'b0, 32'h80000000, 32'h80000000, 1'b1, 32'h80000000);
    cyc(1'b1, 1'b1, 1'b0, 32'h00000000, 32'h80000000, 1'b1, 32'h00000000);
    cyc(1'b1, 1'b1, 1'b0, 32'h80000001, 32'h80000000, 1'b1, 32'h80000000);
    cyc(1'b1, 1'b1, 1'b0, 32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000);
    cyc(1'b1, 1'b1, 1'b0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7F800000);
    cyc(1'b1, 1'b1, 1'b0, 32'h00800001, 32'h80800000, 1'b1, 32'h00000000);
    cyc(1'b1, 1'b1, 1'b0, 32'h40400000, 32'hBF800000, 1'b1, 32'h40000000);
    idle(5);

    // Four back-to-back starts with a two-cycle stall mid-stream
    cyc(1'b1, 1'b1, 1'b0, 32'h40000000, 32'h40000000, 1'b1, 32'h40800000);
    cyc(1'b1, 1'b1, 1'b0, 32'h3F800000, 32'h40000000, 1'b1, 32'h40400000);
    cyc(1'b1, 1'b1, 1'b0, 32'hC0000000, 32'h3F800000, 1'b1, 32'hBF800000);
    cyc(1'b0, 1'b1, 1'b0, 32'h12345678, 32'h12345678, 1'b1, 32'hDEADBEEF);
    cyc(1'b0, 1'b1, 1'b0, 32'h12345678, 32'h12345678, 1'b1, 32'hDEADBEEF);
    cyc(1'b1, 1'b1, 1'b0, 32'h41200000, 32'h41200000, 1'b1, 32'h41A00000);
    idle(6);

    // Reset one cycle after a start: that operation must vanish
    cyc(1'b1, 1'b1, 1'b0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000);
    cyc(1'b1, 1'b0, 1'b1, '0, '0, 1'b0, '0);
    idle(6);

    // Randomised traffic with stalls and rare resets
    a = 32'h3F800000;
    for (int unsigned i = 0; i < 3000; i++) begin
      a = rand_op(a);
      b = rand_op(a);
      cyc(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 75),
          ($urandom_range(0, 199) == 0), a, b, 1'b0, '0);
    end
    idle(10);
    stim_done = 1'b1;
  end

endmodule
